// File: rtl/seq_frame_tx_if.sv
// rtl/seq_frame_tx_if.sv - upstream valid/ready word handshake for the serial frame transmitter
//
// Signals:
//   in_data   payload word offered by the producer
//   in_valid  producer has a word this cycle
//   in_ready  transmitter will take the word on this edge
// Modports:
//   master  producer side (drives in_data/in_valid)
//   slave   transmitter side (drives in_ready)
interface seq_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial frame transmitter: sync header, MSB-first payload, idle zero gap
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   up          word handshake (slave modport: in_data, in_valid in; in_ready out)
//   x           serial line, decoded from registered state only
//   tx_active   high while a header or payload bit is on x
//   frame_done  one-cycle pulse during the first gap bit of each frame
module seq_frame_tx #(
    parameter int         DATA_W   = 8,
    parameter logic [3:0] SYNC     = 4'b1010,
    parameter int         GAP_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_frame_tx_if.slave        up,
    output logic                 x,
    output logic                 tx_active,
    output logic                 frame_done
);

    // The counter only ever has to reach the longest phase length minus one.
    localparam int CNT_MAX_DG = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
    localparam int CNT_MAX    = (CNT_MAX_DG > 4) ? CNT_MAX_DG : 4;
    localparam int CNT_W      = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] shreg;
    logic              ready;
    logic              accept;
    logic [1:0]        sync_idx;

    assign up.in_ready = ready;
    assign accept      = up.in_valid & ready;

    // Header goes out MSB first: bit index 3-cnt, which for a 2-bit count is ~cnt.
    assign sync_idx = ~cnt[1:0];

    // State, counter and payload shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                shreg <= up.in_data;
            end else if (state == ST_DATA) begin
                shreg <= shreg << 1;
            end
        end
    end

    // Next-state and counter sequencing; the counter restarts on every phase change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (accept) begin
                    state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (cnt == SYNC_LAST) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (cnt == DATA_LAST) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = '0;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    // A word taken on the last gap bit starts its header with no idle cycle.
                    state_nxt = accept ? ST_SYNC : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Moore outputs: functions of registered state, counter and shift register only.
    always_comb begin
        x          = 1'b0;
        tx_active  = 1'b0;
        frame_done = 1'b0;
        ready      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_SYNC: begin
                x         = SYNC[sync_idx];
                tx_active = 1'b1;
            end
            ST_DATA: begin
                x         = shreg[DATA_W-1];
                tx_active = 1'b1;
            end
            ST_GAP: begin
                frame_done = (cnt == '0);
                ready      = (cnt == GAP_LAST);
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// tb/tb_seq_frame_tx.sv - self-checking bench for seq_frame_tx (8-bit/gap 2 and 1-bit/gap 1 instances)
module tb_seq_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8;
    logic rst1;
    logic x8, act8, done8;
    logic x1, act1, done1;

    seq_frame_tx_if #(.DATA_W(8)) bus8 ();
    seq_frame_tx_if #(.DATA_W(1)) bus1 ();

    seq_frame_tx #(.DATA_W(8), .SYNC(4'b1010), .GAP_BITS(2)) dut8 (
        .clk        (clk),
        .rst        (rst8),
        .up         (bus8.slave),
        .x          (x8),
        .tx_active  (act8),
        .frame_done (done8)
    );

    seq_frame_tx #(.DATA_W(1), .SYNC(4'b1010), .GAP_BITS(1)) dut1 (
        .clk        (clk),
        .rst        (rst1),
        .up         (bus1.slave),
        .x          (x1),
        .tx_active  (act1),
        .frame_done (done1)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       ex;
        logic       erdy;
        logic       eact;
        logic       edone;
    } vec_t;

    vec_t tbl[$];

    // One expected output cycle of the timeline model.
    typedef struct packed {
        logic x;
        logic act;
        logic done;
        logic rdy;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    function automatic vec_t mk(logic r, logic v, logic [7:0] d,
                                logic ex, logic erdy, logic eact, logic edone);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d;
        t.ex = ex; t.erdy = erdy; t.eact = eact; t.edone = edone;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic ex, input logic erdy,
                        input logic eact, input logic edone);
        chk({name, ".x"},          x8,             ex);
        chk({name, ".in_ready"},   bus8.in_ready,  erdy);
        chk({name, ".tx_active"},  act8,           eact);
        chk({name, ".frame_done"}, done8,          edone);
    endtask

    task automatic chk1(input string name, input logic ex, input logic erdy,
                        input logic eact, input logic edone);
        chk({name, ".x"},          x1,             ex);
        chk({name, ".in_ready"},   bus1.in_ready,  erdy);
        chk({name, ".tx_active"},  act1,           eact);
        chk({name, ".frame_done"}, done1,          edone);
    endtask

    // Model: a frame is a fixed list of output cycles appended to a timeline.
    task automatic put(input int which, input exp_t r);
        if (which == 1) q1.push_back(r);
        else            q8.push_back(r);
    endtask

    task automatic push_frame(input int which, input logic [7:0] d);
        int         dw;
        int         gb;
        logic [3:0] s;
        exp_t       r;
        dw = (which == 1) ? 1 : 8;
        gb = (which == 1) ? 1 : 2;
        s  = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            r = '{x: s[3-k], act: 1'b1, done: 1'b0, rdy: 1'b0};
            put(which, r);
        end
        for (int k = 0; k < dw; k++) begin
            r = '{x: d[dw-1-k], act: 1'b1, done: 1'b0, rdy: 1'b0};
            put(which, r);
        end
        for (int k = 0; k < gb; k++) begin
            r = '{x: 1'b0, act: 1'b0, done: (k == 0), rdy: (k == gb - 1)};
            put(which, r);
        end
    endtask

    function automatic exp_t head(input int which);
        exp_t idle;
        idle = '{x: 1'b0, act: 1'b0, done: 1'b0, rdy: 1'b1};
        if (which == 1) return (q1.size() > 0) ? q1[0] : idle;
        return (q8.size() > 0) ? q8[0] : idle;
    endfunction

    task automatic reset8();
        rst8 = 1'b1;
        bus8.in_valid = 1'b0;
        tick();
        rst8 = 1'b0;
    endtask

    task automatic reset1();
        rst1 = 1'b1;
        bus1.in_valid = 1'b0;
        tick();
        rst1 = 1'b0;
    endtask

    // Checks n cycles of 14-cycle frames on dut8, starting the cycle after an accept.
    task automatic run_frames8(input string name, input logic [27:0] e, input int n);
        for (int i = 0; i < n; i++) begin
            chk8($sformatf("%s[%0d]", name, i), e[n-1-i], (i % 14) == 13,
                 (i % 14) < 12, (i % 14) == 12);
            if (i == 14) bus8.in_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst8 = 1'b1; rst1 = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_data = '0;
        bus1.in_valid = 1'b0; bus1.in_data = '0;

        // Single 0xA5 frame after reset: 1010 10100101 00
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA5, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));

        foreach (tbl[i]) begin
            rst8 = tbl[i].rst;
            bus8.in_valid = tbl[i].valid;
            bus8.in_data = tbl[i].data;
            tick();
            chk8($sformatf("vec%0d", i), tbl[i].ex, tbl[i].erdy, tbl[i].eact, tbl[i].edone);
        end
        bus8.in_valid = 1'b0;

        // Idle for 20 cycles after reset.
        reset8();
        for (int i = 0; i < 20; i++) begin
            chk8($sformatf("idle[%0d]", i), 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end

        // Back-to-back 0x0F then 0xF0 with in_valid held high.
        reset8();
        bus8.in_valid = 1'b1; bus8.in_data = 8'h0F;
        tick();
        bus8.in_data = 8'hF0;
        run_frames8("b2b", 28'b1010_00001111_00_1010_11110000_00, 28);
        bus8.in_valid = 1'b0;

        // Hold-off: 0xFF offered throughout the 0x3C frame.
        reset8();
        bus8.in_valid = 1'b1; bus8.in_data = 8'h3C;
        tick();
        bus8.in_data = 8'hFF;
        run_frames8("hold", 28'b1010_00111100_00_1010_11111111_00, 28);
        bus8.in_valid = 1'b0;

        // Reset during the third payload bit, then a clean 0x81 frame.
        reset8();
        bus8.in_valid = 1'b1; bus8.in_data = 8'hFF;
        tick();
        bus8.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk8("mid.pre", 1'b1, 1'b0, 1'b1, 1'b0);
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        for (int i = 0; i < 14; i++) begin
            chk8($sformatf("mid.post[%0d]", i), 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        bus8.in_valid = 1'b1; bus8.in_data = 8'h81;
        tick();
        bus8.in_valid = 1'b0;
        run_frames8("mid.new", {14'b0, 14'b1010_10000001_00}, 14);

        // DATA_W=1, GAP_BITS=1: continuous 1,0,1,0,1,0 with period 6.
        reset1();
        chk1("p1.reset", 1'b0, 1'b1, 1'b0, 1'b0);
        bus1.in_valid = 1'b1; bus1.in_data = 1'b1;
        tick();
        for (int i = 0; i < 24; i++) begin
            chk1($sformatf("p1[%0d]", i), (i % 6) inside {0, 2, 4}, (i % 6) == 5,
                 (i % 6) < 5, (i % 6) == 5);
            tick();
        end
        bus1.in_valid = 1'b0;

        // Randomized traffic against the timeline model, both instances.
        reset8(); reset1();
        q8.delete(); q1.delete();
        for (int c = 0; c < 3000; c++) begin
            logic v8, v1, r8, r1, a8, a1;
            logic [7:0] d8;
            logic d1;
            v8 = ($urandom_range(0, 99) < 60);
            v1 = ($urandom_range(0, 99) < 60);
            d8 = 8'($urandom);
            d1 = 1'($urandom);
            r8 = ($urandom_range(0, 99) == 0);
            r1 = ($urandom_range(0, 99) == 0);
            rst8 = r8; rst1 = r1;
            bus8.in_valid = v8; bus8.in_data = d8;
            bus1.in_valid = v1; bus1.in_data = d1;
            a8 = v8 && head(0).rdy;
            a1 = v1 && head(1).rdy;
            tick();
            if (r8) q8.delete();
            else begin
                if (q8.size() > 0) void'(q8.pop_front());
                if (a8) push_frame(0, d8);
            end
            if (r1) q1.delete();
            else begin
                if (q1.size() > 0) void'(q1.pop_front());
                if (a1) push_frame(1, {7'b0, d1});
            end
            chk8($sformatf("rnd8[%0d]", c), head(0).x, head(0).rdy, head(0).act, head(0).done);
            chk1($sformatf("rnd1[%0d]", c), head(1).x, head(1).rdy, head(1).act, head(1).done);
        end
        rst8 = 1'b0; rst1 = 1'b0;
        bus8.in_valid = 1'b0; bus1.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter, one bit per clock.
- Each accepted parallel word goes out as a frame: a 4-bit sync header (1,0,1,0), then the payload MSB first, then a run of idle zeros.
- Drives the serial line that feeds the team's Moore-style 1010 sync detectors.
- Upstream side is a valid/ready handshake.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- SYNC, 4'b1010, header pattern, sent MSB first.
- GAP_BITS, 2, number of zero bits guaranteed between back-to-back frames (>=1).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous reset, active-high.
- in_data  input  DATA_W  payload word, sampled on the accept edge only.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word this cycle.
- x  output  1  serial line, registered (Moore) output.
- tx_active  output  1  high while a SYNC or DATA bit is on x.
- frame_done  output  1  one-cycle pulse, high during the first GAP bit of each frame.

Behaviour:
- Reset (rst=1 at posedge) forces:
  - state=IDLE, x=0, in_ready=1, tx_active=0, frame_done=0;
  - shift register and counters cleared.
- Reset mid-frame aborts the frame. The partially sent word is discarded and never resent. The cycle after reset shows x=0 and in_ready=1.
- Accept occurs at a posedge with in_valid=1 and in_ready=1. in_data is latched into a DATA_W shift register on that edge. in_data and in_valid are don't-care after the accept edge.
- States and outputs (all outputs decoded from registered state/counters, no combinational path from inputs to outputs):
  - IDLE: x=0, in_ready=1. Accept -> SYNC with bit counter=0. Otherwise stay in IDLE.
  - SYNC: x=SYNC[3-cnt], tx_active=1, in_ready=0. After 4 cycles -> DATA with counter=0.
  - DATA: x=shreg[DATA_W-1]; shift left each cycle; tx_active=1, in_ready=0. After DATA_W cycles -> GAP with counter=0.
  - GAP: x=0, tx_active=0. frame_done=1 only when counter=0.
    - in_ready=1 only on the final GAP cycle (counter=GAP_BITS-1).
    - Accept on that edge -> SYNC directly (back-to-back).
    - Otherwise, at the end of the final GAP cycle -> IDLE.
- Latency: accept at edge T0 gives:
  - first sync bit on x in the cycle after T0;
  - payload MSB at T0+5;
  - last payload bit at T0+4+DATA_W;
  - frame_done at T0+5+DATA_W.
- Back-to-back frame period is exactly 4+DATA_W+GAP_BITS cycles, and the zero run between frames is exactly GAP_BITS. With an IDLE gap the zero run is longer than GAP_BITS and unbounded.
- in_valid arriving while in_ready=0 is held off. No data loss and no overwrite of the active word.
- Counter width is clog2(max(4, DATA_W, GAP_BITS)). No wrap beyond the terminal count; the counter resets on every state change.
- If the payload itself contains a 1010 run, it is transmitted unmodified. There is no bit stuffing in this block.

Test Plan:
- DATA_W=8, GAP_BITS=2: reset, then in_valid=1 with in_data=0xA5 for one cycle -> x over 14 cycles = 1,0,1,0, 1,0,1,0,0,1,0,1, 0,0. tx_active high for 12 cycles. frame_done pulses once at the 13th cycle. in_ready low from accept until the 14th cycle.
- Back-to-back: in_valid held high with words 0x0F then 0xF0 -> x = 1010 00001111 00 1010 11110000 00. Second accept occurs on the final GAP cycle. Frame period is 14 cycles.
- Idle: in_valid=0 for 20 cycles after reset -> x=0, in_ready=1, tx_active=0, frame_done=0 throughout.
- Hold-off: accept 0x3C, drive in_valid=1 with in_data=0xFF on every busy cycle -> x carries 0x3C unchanged. 0xFF is accepted only on the final GAP cycle and transmitted next.
- Reset mid-DATA: assert rst for one cycle during the 3rd payload bit -> next cycle x=0, in_ready=1, tx_active=0, no frame_done. A fresh accept of 0x81 then yields the full 1010 10000001 00 frame.
- Param sweep: DATA_W=1 and GAP_BITS=1 with 0x1 back-to-back -> x = 1,0,1,0,1,0 repeating, period 6 cycles.
